// File: rtl/gate_sequence_ctrl_if.sv
// Handshake bundle between the gate sequencer, its controller and the multiplier.
// master drives the requests and mult_done, slave is the sequencer.
interface gate_sequence_ctrl_if #(
   parameter int GATE_DEPTH = 8
);
   localparam int AW = (GATE_DEPTH > 1) ? $clog2(GATE_DEPTH) : 1;
   localparam int CW = $clog2(GATE_DEPTH + 1);

   logic          start;
   logic          abort;
   logic [CW-1:0] num_gates;
   logic          mult_done;
   logic [AW-1:0] gate_addr;
   logic          mult_start;
   logic          state_we;
   logic          busy;
   logic          done;
   logic [CW-1:0] gates_done;
   logic          error;

   modport master (
      output start, abort, num_gates, mult_done,
      input  gate_addr, mult_start, state_we, busy, done, gates_done, error
   );

   modport slave (
      input  start, abort, num_gates, mult_done,
      output gate_addr, mult_start, state_we, busy, done, gates_done, error
   );
endinterface

// File: rtl/gate_sequence_ctrl.sv
// Steps a gate program through the gate-state multiplier, one fetch/mult/commit per gate.
// Optional GATE_SEQ_TIMEOUT_EN adds a mult_done watchdog that raises a sticky error.
module gate_sequence_ctrl #(
   parameter int N              = 2,
   parameter int GATE_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                clk,
   input  logic                reset,
   gate_sequence_ctrl_if.slave bus
);
   localparam int AW = (GATE_DEPTH > 1) ? $clog2(GATE_DEPTH) : 1;
   localparam int CW = $clog2(GATE_DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(GATE_DEPTH);

   if (N < 1 || GATE_DEPTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("gate_sequence_ctrl: N, GATE_DEPTH and TIMEOUT_CYCLES must be >= 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_START,
      S_WAIT,
      S_COMMIT,
      S_DONE
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] len_q, len_n;
   logic [AW-1:0] addr_q, addr_n;
   logic [CW-1:0] cnt_q, cnt_n;
   logic          err_q, err_n;
   logic          mult_start_q, state_we_q, done_q, busy_q;
   logic          timeout;

`ifdef GATE_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] wcnt_q;

   // wcnt_q counts WAIT cycles already spent; zero on the first WAIT cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wcnt_q <= '0;
      end else if (state == S_WAIT) begin
         wcnt_q <= wcnt_q + TW'(1);
      end else begin
         wcnt_q <= '0;
      end
   end

   assign timeout = (wcnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_n = state;
      len_n   = len_q;
      addr_n  = addr_q;
      cnt_n   = cnt_q;
      err_n   = err_q;
      unique case (state)
         S_IDLE: begin
            if (bus.start) begin
               len_n   = (bus.num_gates > DEPTH_C) ? DEPTH_C : bus.num_gates;
               cnt_n   = '0;
               err_n   = 1'b0;
               addr_n  = '0;
               state_n = (len_n == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: state_n = S_START;
         S_START: state_n = S_WAIT;
         S_WAIT: begin
            if (bus.mult_done) begin
               state_n = S_COMMIT;
            end else if (timeout) begin
               err_n   = 1'b1;
               state_n = S_DONE;
            end
         end
         S_COMMIT: begin
            if (cnt_q == len_q) begin
               state_n = S_DONE;
            end else begin
               addr_n  = addr_q + AW'(1);
               state_n = S_FETCH;
            end
         end
         S_DONE: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      // abort outranks mult_done and the timeout in every busy state
      if (state != S_IDLE && bus.abort) begin
         state_n = S_IDLE;
         addr_n  = addr_q;
         err_n   = err_q;
      end
      if (state_n == S_COMMIT) begin
         cnt_n = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         len_q        <= '0;
         addr_q       <= '0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
         mult_start_q <= 1'b0;
         state_we_q   <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state        <= state_n;
         len_q        <= len_n;
         addr_q       <= addr_n;
         cnt_q        <= cnt_n;
         err_q        <= err_n;
         mult_start_q <= (state_n == S_START);
         state_we_q   <= (state_n == S_COMMIT);
         done_q       <= (state_n == S_DONE);
         busy_q       <= (state_n != S_IDLE);
      end
   end

   assign bus.gate_addr  = addr_q;
   assign bus.mult_start = mult_start_q;
   assign bus.state_we   = state_we_q;
   assign bus.done       = done_q;
   assign bus.busy       = busy_q;
   assign bus.gates_done = cnt_q;
   assign bus.error      = err_q;
endmodule

// File: tb/tb_gate_sequence_ctrl.sv
// Directed bench for gate_sequence_ctrl with a scripted multiplier responder.
// Define GATE_SEQ_TIMEOUT_EN for the build to also exercise the watchdog.
module tb_gate_sequence_ctrl;
   logic clk;
   logic reset;

   gate_sequence_ctrl_if #(.GATE_DEPTH(8)) bus ();

   gate_sequence_ctrl #(
      .N(2),
      .GATE_DEPTH(8),
      .TIMEOUT_CYCLES(64)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int failures;

   int n_ms, n_we, n_done, max_addr, addr_err;
   int c_ms1, c_ms2, c_we1, c_done, c_idle, c_abort;
   bit timed_out;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.num_gates = '0;
      bus.mult_done = 1'b0;
   endtask

   // start a program; the responder answers each mult_start after lat cycles
   task automatic run(input int ng, input int lat, input int abort_nth,
                      input bit stray, input int budget);
      int  since;
      int  md_cnt;
      int  cyc_i;
      bit  pend;
      n_ms = 0; n_we = 0; n_done = 0; max_addr = 0; addr_err = 0;
      c_ms1 = -1; c_ms2 = -1; c_we1 = -1; c_done = -1; c_idle = -1;
      c_abort = -1; timed_out = 1'b0;
      since = 0; md_cnt = 0; pend = 1'b0;
      bus.num_gates = 4'(ng);
      bus.start     = 1'b1;
      cyc();
      cyc_i = 1;
      forever begin
         bus.start     = 1'b0;
         bus.abort     = 1'b0;
         bus.mult_done = 1'b0;
         if (!bus.busy) begin
            c_idle = cyc_i;
            break;
         end
         if (cyc_i > budget) begin
            timed_out = 1'b1;
            break;
         end
         if (int'(bus.gate_addr) > max_addr) max_addr = int'(bus.gate_addr);
         if (bus.done) begin
            n_done++;
            if (c_done < 0) c_done = cyc_i;
         end
         if (bus.state_we) begin
            if (int'(bus.gate_addr) != n_we) addr_err++;
            if (c_we1 < 0) c_we1 = cyc_i;
            n_we++;
         end
         if (bus.mult_start) begin
            n_ms++;
            if (n_ms == 1) c_ms1 = cyc_i;
            if (n_ms == 2) c_ms2 = cyc_i;
            pend  = 1'b1;
            since = 0;
         end else if (pend) begin
            since++;
            if (since == lat) begin
               bus.mult_done = 1'b1;
               pend = 1'b0;
               md_cnt++;
               if (md_cnt == abort_nth) begin
                  bus.abort = 1'b1;
                  c_abort   = cyc_i;
               end
            end
         end
         if (stray && (cyc_i == 1 || bus.state_we)) begin
            bus.mult_done = 1'b1;
            bus.start     = 1'b1;
            bus.num_gates = 4'd1;
         end
         cyc();
         cyc_i++;
      end
      idle_inputs();
      if (timed_out) begin
         checks++;
         failures++;
         $display("FAIL run_budget ng=%0d still busy after %0d cycles", ng, budget);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle_inputs();
      repeat (2) cyc();
      checks++;
      if ({bus.busy, bus.done, bus.mult_start, bus.state_we, bus.error} !== 5'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=00000",
                  {bus.busy, bus.done, bus.mult_start, bus.state_we, bus.error});
      end
      checks++;
      if (bus.gate_addr !== 3'd0 || bus.gates_done !== 4'd0) begin
         failures++;
         $display("FAIL reset_counts addr=%0d gd=%0d exp=0,0",
                  bus.gate_addr, bus.gates_done);
      end
      reset = 1'b1;
      cyc();
   endtask

   task automatic test_three_gates();
      run(3, 4, 0, 1'b0, 200);
      checks++;
      if (n_ms != 3 || n_we != 3 || n_done != 1) begin
         failures++;
         $display("FAIL three_pulses ms=%0d we=%0d done=%0d exp=3,3,1", n_ms, n_we, n_done);
      end
      checks++;
      if (addr_err != 0 || max_addr != 2) begin
         failures++;
         $display("FAIL three_addr errs=%0d max=%0d exp=0,2", addr_err, max_addr);
      end
      checks++;
      if (bus.gates_done !== 4'd3) begin
         failures++;
         $display("FAIL three_gates_done got=%0d exp=3", bus.gates_done);
      end
      checks++;
      if (c_ms1 != 2 || c_we1 != 7 || c_ms2 != 9) begin
         failures++;
         $display("FAIL three_latency ms1=%0d we1=%0d ms2=%0d exp=2,7,9", c_ms1, c_we1, c_ms2);
      end
      checks++;
      if (c_done != 22 || c_idle != 23) begin
         failures++;
         $display("FAIL three_done_cycle done=%0d idle=%0d exp=22,23", c_done, c_idle);
      end
      checks++;
      if (bus.error !== 1'b0) begin
         failures++;
         $display("FAIL three_error got=%b exp=0", bus.error);
      end
   endtask

   task automatic test_zero_gates();
      run(0, 4, 0, 1'b0, 20);
      checks++;
      if (n_ms != 0 || n_we != 0 || n_done != 1) begin
         failures++;
         $display("FAIL zero_pulses ms=%0d we=%0d done=%0d exp=0,0,1", n_ms, n_we, n_done);
      end
      checks++;
      if (c_done < 1 || c_done > 2 || bus.gates_done !== 4'd0) begin
         failures++;
         $display("FAIL zero_done done_cyc=%0d gd=%0d exp=1..2,0", c_done, bus.gates_done);
      end
   endtask

   task automatic test_clamp();
      run(12, 2, 0, 1'b0, 300);
      checks++;
      if (n_we != 8 || n_ms != 8 || n_done != 1) begin
         failures++;
         $display("FAIL clamp_pulses ms=%0d we=%0d done=%0d exp=8,8,1", n_ms, n_we, n_done);
      end
      checks++;
      if (max_addr != 7 || addr_err != 0 || bus.gates_done !== 4'd8) begin
         failures++;
         $display("FAIL clamp_addr max=%0d errs=%0d gd=%0d exp=7,0,8",
                  max_addr, addr_err, bus.gates_done);
      end
   endtask

   task automatic test_abort();
      run(4, 4, 2, 1'b0, 200);
      checks++;
      if (n_we != 1 || n_done != 0) begin
         failures++;
         $display("FAIL abort_pulses we=%0d done=%0d exp=1,0", n_we, n_done);
      end
      checks++;
      if (c_abort != 13 || c_idle != 14) begin
         failures++;
         $display("FAIL abort_idle abort=%0d idle=%0d exp=13,14", c_abort, c_idle);
      end
      checks++;
      if (bus.gates_done !== 4'd1) begin
         failures++;
         $display("FAIL abort_gates_done got=%0d exp=1", bus.gates_done);
      end
   endtask

   task automatic test_stray();
      run(3, 4, 0, 1'b1, 200);
      checks++;
      if (n_ms != 3 || n_we != 3 || n_done != 1 || addr_err != 0) begin
         failures++;
         $display("FAIL stray_pulses ms=%0d we=%0d done=%0d errs=%0d exp=3,3,1,0",
                  n_ms, n_we, n_done, addr_err);
      end
      checks++;
      if (c_we1 != 7 || c_done != 22 || bus.gates_done !== 4'd3) begin
         failures++;
         $display("FAIL stray_timing we1=%0d done=%0d gd=%0d exp=7,22,3",
                  c_we1, c_done, bus.gates_done);
      end
   endtask

   task automatic test_start_abort_idle();
      bus.num_gates = 4'd2;
      bus.start     = 1'b1;
      bus.abort     = 1'b1;
      cyc();
      idle_inputs();
      checks++;
      if (bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL start_abort_idle busy=%b exp=1", bus.busy);
      end
      cyc();
      bus.abort = 1'b1;
      cyc();
      bus.abort = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.mult_start !== 1'b0) begin
         failures++;
         $display("FAIL abort_fetch busy=%b ms=%b exp=0,0", bus.busy, bus.mult_start);
      end
   endtask

   task automatic test_reset_mid();
      bus.num_gates = 4'd5;
      bus.start     = 1'b1;
      cyc();
      bus.start = 1'b0;
      repeat (10) cyc();
      #2 reset = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.gates_done !== 4'd0 || bus.mult_start !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid busy=%b gd=%0d ms=%b exp=0,0,0",
                  bus.busy, bus.gates_done, bus.mult_start);
      end
      cyc();
      reset = 1'b1;
      cyc();
   endtask

`ifdef GATE_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      run(2, 1000, 0, 1'b0, 200);
      checks++;
      if (n_we != 0 || n_done != 1 || c_done != 67) begin
         failures++;
         $display("FAIL timeout_done we=%0d done=%0d cyc=%0d exp=0,1,67", n_we, n_done, c_done);
      end
      checks++;
      if (bus.error !== 1'b1) begin
         failures++;
         $display("FAIL timeout_error got=%b exp=1", bus.error);
      end
      run(1, 4, 0, 1'b0, 100);
      checks++;
      if (bus.error !== 1'b0 || n_we != 1) begin
         failures++;
         $display("FAIL timeout_clear err=%b we=%0d exp=0,1", bus.error, n_we);
      end
   endtask
`endif

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      idle_inputs();
      test_reset();
      test_three_gates();
      test_zero_gates();
      test_clamp();
      test_abort();
      test_stray();
      test_start_abort_idle();
      test_reset_mid();
`ifdef GATE_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
